// File: rtl/pid_wt_sched.sv
`default_nettype none
// ============================================================================
// Module   : pid_wt_sched
// Brief    : Time-slot scheduler for the shared PID pipeline. It issues a
//            done_read/sta pair per turbine and counts done_sig completions.
//            Optional watchdog: define PID_SCHED_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pid_wt_sched #(
    parameter int N_WT      = 8,
    parameter int READ_LEAD = 15,
    parameter int SLOT_GAP  = 1,
    parameter int PIPE_LAT  = 20,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_req,
    input  logic             done_sig,
    output logic             busy,
    output logic             done_read,
    output logic             sta,
    output logic [CNT_W-1:0] slot_idx,
    output logic             step_done,
    output logic             first_step,
    output logic             err_overrun,
    output logic             err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int               GAP_W      = (SLOT_GAP > 1) ? $clog2(SLOT_GAP) : 1;
    localparam logic [CNT_W-1:0] c_n_wt     = CNT_W'(N_WT);
    localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(SLOT_GAP - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_iss_cnt;
    logic [CNT_W-1:0] r_cmp_cnt;
    logic [CNT_W-1:0] r_rd_idx;
    logic [GAP_W-1:0] r_gap;
    logic             r_sta_sr [READ_LEAD];
    logic [CNT_W-1:0] r_idx_sr [READ_LEAD];
    logic             r_busy;
    logic             r_done_read;
    logic             r_step_done;
    logic             r_first;
    logic             r_ovr;

    logic             w_in_sweep;
    logic             w_cnt_full;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_ds_err;
    logic             w_req_err;

`ifdef PID_SCHED_WATCHDOG_EN
    localparam int              WD_W       = $clog2(PIPE_LAT + 4) + 1;
    localparam logic [WD_W-1:0] c_wd_limit = WD_W'(PIPE_LAT + 2);

    logic [WD_W-1:0] r_wd;
    logic            r_wd_run;
    logic            r_wd_fired;
    logic            r_err_to;
    logic            w_sr_pending;
    logic            w_last_sta;

    // The last sta is the one leaving the delay line with nothing queued behind it.
    always_comb begin
        w_sr_pending = 1'b0;
        for (int i = 0; i < READ_LEAD - 1; i++) begin
            w_sr_pending = w_sr_pending | r_sta_sr[i];
        end
    end

    assign w_last_sta  = (r_state == S_DRAIN) && r_sta_sr[READ_LEAD-1] && !w_sr_pending;
    assign err_timeout = r_err_to;
`else
    assign err_timeout = 1'b0;
`endif

    assign w_in_sweep = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_cnt_full = (r_cmp_cnt == c_n_wt);
    assign w_cnt_next = (done_sig && w_in_sweep && !w_cnt_full) ? r_cmp_cnt + 1'b1 : r_cmp_cnt;
    assign w_ds_err   = done_sig && (!w_in_sweep || w_cnt_full);
    assign w_req_err  = step_req && (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_iss_cnt   <= '0;
            r_cmp_cnt   <= '0;
            r_rd_idx    <= '0;
            r_gap       <= '0;
            r_busy      <= 1'b0;
            r_done_read <= 1'b0;
            r_step_done <= 1'b0;
            r_first     <= 1'b1;
            r_ovr       <= 1'b0;
            for (int i = 0; i < READ_LEAD; i++) begin
                r_sta_sr[i] <= 1'b0;
                r_idx_sr[i] <= '0;
            end
`ifdef PID_SCHED_WATCHDOG_EN
            r_wd       <= '0;
            r_wd_run   <= 1'b0;
            r_wd_fired <= 1'b0;
            r_err_to   <= 1'b0;
`endif
        end else begin
            r_sta_sr[0] <= r_done_read;
            r_idx_sr[0] <= r_done_read ? r_rd_idx : '0;
            for (int i = 1; i < READ_LEAD; i++) begin
                r_sta_sr[i] <= r_sta_sr[i-1];
                r_idx_sr[i] <= r_idx_sr[i-1];
            end

            if (w_req_err || w_ds_err) begin
                r_ovr <= 1'b1;
            end

            r_done_read <= 1'b0;
            r_step_done <= 1'b0;
            r_cmp_cnt   <= w_cnt_next;

            case (r_state)
                S_IDLE: begin
                    if (step_req) begin
                        r_state     <= S_ISSUE;
                        r_busy      <= 1'b1;
                        r_done_read <= 1'b1;
                        r_rd_idx    <= '0;
                        r_iss_cnt   <= CNT_W'(1);
                        r_gap       <= '0;
                        r_cmp_cnt   <= '0;
`ifdef PID_SCHED_WATCHDOG_EN
                        r_wd_run    <= 1'b0;
                        r_wd_fired  <= 1'b0;
`endif
                    end
                end
                S_ISSUE: begin
                    if (r_done_read && (r_iss_cnt == c_n_wt)) begin
                        r_state <= S_DRAIN;
                    end else if (r_gap == c_gap_last) begin
                        r_done_read <= 1'b1;
                        r_rd_idx    <= r_iss_cnt;
                        r_iss_cnt   <= r_iss_cnt + 1'b1;
                        r_gap       <= '0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_cnt_next == c_n_wt) begin
                        r_state     <= S_DONE;
                        r_step_done <= 1'b1;
                    end
`ifdef PID_SCHED_WATCHDOG_EN
                    else if (r_wd_run && (r_wd == c_wd_limit)) begin
                        r_state     <= S_DONE;
                        r_step_done <= 1'b1;
                        r_err_to    <= 1'b1;
                        r_wd_fired  <= 1'b1;
                        r_wd_run    <= 1'b0;
                    end else if (w_last_sta) begin
                        r_wd_run <= 1'b1;
                        r_wd     <= '0;
                    end else if (r_wd_run) begin
                        r_wd <= r_wd + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
`ifdef PID_SCHED_WATCHDOG_EN
                    // An aborted sweep never loaded valid state, so keep the init flag.
                    if (!r_wd_fired) begin
                        r_first <= 1'b0;
                    end
`else
                    r_first <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done_read   = r_done_read;
    assign sta         = r_sta_sr[READ_LEAD-1];
    assign slot_idx    = r_idx_sr[READ_LEAD-1];
    assign step_done   = r_step_done;
    assign first_step  = r_first;
    assign err_overrun = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_pid_wt_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pid_wt_sched
// Brief    : Self-checking bench for pid_wt_sched with a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pid_wt_sched;

    localparam int N  = 4;
    localparam int L  = 15;
    localparam int G  = 1;
    localparam int PL = 20;
    localparam int W  = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         step_req = 1'b0;
    logic         done_sig = 1'b0;
    logic         busy, done_read, sta, step_done, first_step, err_overrun, err_timeout;
    logic [W-1:0] slot_idx;

    logic         g3_req = 1'b0;
    logic         g3_ds = 1'b0;
    logic         g3_busy, g3_dr, g3_sta, g3_sd, g3_first, g3_ovr, g3_to;
    logic [W-1:0] g3_idx;

    always #5 clk = ~clk;

    pid_wt_sched #(.N_WT(N), .READ_LEAD(L), .SLOT_GAP(G), .PIPE_LAT(PL), .CNT_W(W)) u_dut (
        .clk(clk), .rst(rst), .step_req(step_req), .done_sig(done_sig),
        .busy(busy), .done_read(done_read), .sta(sta), .slot_idx(slot_idx),
        .step_done(step_done), .first_step(first_step),
        .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    pid_wt_sched #(.N_WT(N), .READ_LEAD(L), .SLOT_GAP(3), .PIPE_LAT(PL), .CNT_W(W)) u_dut_g3 (
        .clk(clk), .rst(rst), .step_req(g3_req), .done_sig(g3_ds),
        .busy(g3_busy), .done_read(g3_dr), .sta(g3_sta), .slot_idx(g3_idx),
        .step_done(g3_sd), .first_step(g3_first),
        .err_overrun(g3_ovr), .err_timeout(g3_to)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Behavioural model: sweep start cycle, completion count, expected flags.
    int m_ts = -1000;
    int m_cnt = 0;
    bit m_to_fired = 0;
    bit e_busy = 0, e_sd = 0, e_first = 1, e_ovr = 0, e_to = 0;

    // Pipeline stand-in and stimulus controls.
    int pend[$];
    int g3_pend[$];
    int lat = 20;
    bit drop_last = 0;
    bit nx_rst = 1, nx_req = 0, nx_ds = 0, g3_nx_req = 0;

    int o_dr[$], o_sta[$], o_sd[$];
    int q3_dr[$], q3_sta[$], q3_idx[$], q3_sd[$];

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp_v);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -999;
    endfunction

    function automatic bit on_grid(input int d);
        return (d >= 0) && (d <= (N - 1) * G) && ((d % G) == 0);
    endfunction

    task automatic model_update(input bit r, input bit q, input bit d);
        bit n_busy, n_sd, n_first, n_ovr, n_to;
        if (r) begin
            n_busy = 0; n_sd = 0; n_first = 1; n_ovr = 0; n_to = 0;
            m_ts = -1000; m_cnt = 0; m_to_fired = 0;
        end else begin
            n_busy = e_busy; n_sd = 0; n_first = e_first; n_ovr = e_ovr; n_to = e_to;
            if (e_sd) begin
                n_busy = 0;
                if (!m_to_fired) n_first = 0;
            end
            if (q) begin
                if (e_busy) n_ovr = 1;
                else begin
                    m_ts = cyc; m_cnt = 0; n_busy = 1; m_to_fired = 0;
                end
            end
            if (d) begin
                if (!e_busy || e_sd || m_cnt == N) n_ovr = 1;
                else begin
                    m_cnt++;
                    if (m_cnt == N) n_sd = 1;
                end
            end
`ifdef PID_SCHED_WATCHDOG_EN
            if (e_busy && !e_sd && !n_sd && (cyc + 1 == m_ts + 1 + L + (N - 1) * G + PL + 4)) begin
                n_sd = 1; n_to = 1; m_to_fired = 1;
            end
`endif
        end
        e_busy = n_busy; e_sd = n_sd; e_first = n_first; e_ovr = n_ovr; e_to = n_to;
    endtask

    task automatic tick();
        bit ds, ds3, e_dr, e_st;
        @(posedge clk);
        cyc++;
        #1;
        rst      = nx_rst;
        step_req = nx_req;
        g3_req   = g3_nx_req;
        ds = nx_ds;
        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i] == cyc) begin ds = 1; pend.delete(i); end
        ds3 = 0;
        for (int i = g3_pend.size() - 1; i >= 0; i--)
            if (g3_pend[i] == cyc) begin ds3 = 1; g3_pend.delete(i); end
        done_sig = ds;
        g3_ds    = ds3;
        if (nx_rst) begin pend.delete(); g3_pend.delete(); end
        #3;
        e_dr = on_grid(cyc - m_ts - 1);
        e_st = on_grid(cyc - m_ts - 1 - L);
        chk("busy", busy, e_busy);
        chk("done_read", done_read, e_dr);
        chk("sta", sta, e_st);
        if (e_st) chk("slot_idx", slot_idx, (cyc - m_ts - 1 - L) / G);
        chk("step_done", step_done, e_sd);
        chk("first_step", first_step, e_first);
        chk("err_overrun", err_overrun, e_ovr);
        chk("err_timeout", err_timeout, e_to);
        if (done_read) o_dr.push_back(cyc);
        if (sta) begin
            o_sta.push_back(cyc);
            if (!rst && !(drop_last && slot_idx == W'(N - 1))) pend.push_back(cyc + lat);
        end
        if (step_done) o_sd.push_back(cyc);
        if (g3_dr) q3_dr.push_back(cyc);
        if (g3_sta) begin
            q3_sta.push_back(cyc);
            q3_idx.push_back(int'(g3_idx));
            if (!rst) g3_pend.push_back(cyc + 20);
        end
        if (g3_sd) q3_sd.push_back(cyc);
        model_update(rst, step_req, done_sig);
        nx_rst = 0; nx_req = 0; nx_ds = 0; g3_nx_req = 0;
    endtask

    task automatic clr_obs();
        o_dr.delete(); o_sta.delete(); o_sd.delete();
        q3_dr.delete(); q3_sta.delete(); q3_idx.delete(); q3_sd.delete();
    endtask

    task automatic run_sweep(input int lat_i, input bit drop, input int extra_at,
                             input int rst_at, input int budget);
        lat = lat_i; drop_last = drop;
        nx_req = 1;
        tick();
        for (int r = 1; r < budget; r++) begin
            if (r == extra_at && e_busy) nx_req = 1;
            if (r == rst_at) nx_rst = 1;
            tick();
            if (!e_busy) break;
        end
        if (e_busy) begin nx_rst = 1; tick(); end
        drop_last = 0;
    endtask

    initial begin
        int b, cnt, gap, spur;
        int lat_r, extra, rst_r;
        bit drop_r;

        nx_rst = 1; tick();
        nx_rst = 1; tick();

        // Nominal sweep on the main instance; SLOT_GAP=3 instance starts at rel 0.
        clr_obs(); b = cyc + 1; lat = 20;
        for (int r = 0; r < 60; r++) begin
            nx_req = (r == 10); g3_nx_req = (r == 0); tick();
        end
        chk("nom_dr_first", qget(o_dr, 0) - b, 11);
        chk("nom_dr_last", qget(o_dr, 3) - b, 14);
        chk("nom_sta_first", qget(o_sta, 0) - b, 26);
        chk("nom_sta_last", qget(o_sta, 3) - b, 29);
        chk("nom_sta_count", o_sta.size(), 4);
        chk("nom_step_done", qget(o_sd, 0) - b, 50);
        chk("nom_first_cleared", first_step, 0);
        chk("g3_dr1", qget(q3_dr, 1) - b, 4);
        chk("g3_dr3", qget(q3_dr, 3) - b, 10);
        chk("g3_sta0", qget(q3_sta, 0) - b, 16);
        chk("g3_sta3", qget(q3_sta, 3) - b, 25);
        chk("g3_idx3", qget(q3_idx, 3), 3);
        chk("g3_step_done", qget(q3_sd, 0) - b, 46);

        // Repeated request during a sweep.
        clr_obs(); b = cyc + 1;
        for (int r = 0; r < 60; r++) begin
            nx_req = (r == 10) || (r == 12); tick();
        end
        chk("rep_overrun", err_overrun, 1);
        chk("rep_sta_count", o_sta.size(), 4);
        chk("rep_step_done", qget(o_sd, 0) - b, 50);

        // Pipeline drops the last completion.
        nx_rst = 1; tick();
        clr_obs(); b = cyc + 1; drop_last = 1;
        for (int r = 0; r < 80; r++) begin
            nx_req = (r == 10); tick();
        end
        drop_last = 0;
`ifdef PID_SCHED_WATCHDOG_EN
        chk("to_step_done", qget(o_sd, 0) - b, 53);
        chk("to_flag", err_timeout, 1);
        chk("to_first_kept", first_step, 1);
`else
        chk("hang_busy", busy, 1);
        chk("hang_no_done", o_sd.size(), 0);
`endif

        // Reset mid-sweep, then a fresh sweep.
        nx_rst = 1; tick();
        clr_obs(); b = cyc + 1;
        for (int r = 0; r < 80; r++) begin
            nx_req = (r == 10) || (r == 30); nx_rst = (r == 20); tick();
        end
        cnt = 0;
        foreach (o_sta[i]) if (o_sta[i] - b >= 26 && o_sta[i] - b <= 29) cnt++;
        chk("rst_no_sta", cnt, 0);
        chk("rst_sta_first", qget(o_sta, 0) - b, 46);
        chk("rst_step_done", qget(o_sd, 0) - b, 70);

        // Spurious completion while idle.
        nx_rst = 1; tick();
        clr_obs(); b = cyc + 1;
        for (int r = 0; r < 60; r++) begin
            nx_ds = (r == 3); nx_req = (r == 10); tick();
        end
        chk("spur_overrun", err_overrun, 1);
        chk("spur_step_done", qget(o_sd, 0) - b, 50);

        // Randomized sweeps.
        for (int s = 0; s < 25; s++) begin
            gap  = $urandom_range(3, 10);
            spur = ($urandom_range(0, 2) == 0) ? $urandom_range(0, gap - 1) : -1;
            for (int r = 0; r < gap; r++) begin
                nx_ds = (r == spur); tick();
            end
            lat_r  = $urandom_range(1, 20);
            drop_r = ($urandom_range(0, 4) == 0);
            extra  = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 40) : -1;
            rst_r  = ($urandom_range(0, 5) == 0) ? $urandom_range(2, 40) : -1;
            run_sweep(lat_r, drop_r, extra, rst_r, 120);
            if ($urandom_range(0, 3) == 0) begin nx_rst = 1; tick(); end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pid_wt_sched.md
# pid_wt_sched

Time-slot scheduler for the shared 64-bit floating-point PID/transfer-function pipeline used by the wind-turbine models. On each simulation step request it issues, for every turbine sharing the pipeline, the FIFO pre-read strobe (`done_read`), then the pipeline start strobe (`sta`) with its slot index. It then counts the pipeline's `done_sig` completions and reports end-of-step. It also flags the first sweep after reset, which the datapath uses to load initial values.

## Interface
- `N_WT`, 8: turbines time-multiplexed on the pipeline (1..255).
- `READ_LEAD`, 15: cycles from a slot's `done_read` to its `sta` (≥1).
- `SLOT_GAP`, 1: cycles between consecutive slot issues (≥1; 1 = back-to-back).
- `PIPE_LAT`, 20: nominal `sta`→`done_sig` latency; used only by the watchdog.
- `CNT_W`, 8: width of slot/completion counters; must hold `N_WT`.
- `clk` in 1: the single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `step_req` in 1: one-cycle pulse; start a sweep.
- `done_sig` in 1: one-cycle completion pulse from the pipeline, one per `sta`.
- `busy` out 1: sweep in progress.
- `done_read` out 1: FIFO pre-read strobe, one pulse per slot.
- `sta` out 1: pipeline start strobe, one pulse per slot.
- `slot_idx` out CNT_W: turbine index, valid while `sta`=1.
- `step_done` out 1: one-cycle pulse; all `N_WT` completions received.
- `first_step` out 1: high from reset until the first `step_done`.
- `err_overrun` out 1: sticky protocol-error flag.
- `err_timeout` out 1: sticky watchdog flag.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on `step_req`, go to ISSUE and clear the issue and completion counters.
- ISSUE: the issue counter emits `done_read` every `SLOT_GAP` cycles, `N_WT` pulses total, starting in the first ISSUE cycle.
  - `sta` is `done_read` delayed exactly `READ_LEAD` cycles via a 1-bit shift register.
  - `slot_idx` is delayed alongside it via a parallel CNT_W-wide shift register.
  - Go to DRAIN after the last `done_read` is emitted.
- DRAIN: wait for the completion count to reach `N_WT`. Pending `sta` pulses still drain out of the shift register.
- `done_sig` is counted in both ISSUE and DRAIN.
- When the count equals `N_WT` at the end of a cycle, go to DONE.
- DONE: `step_done`=1 for one cycle, clear `first_step`, return to IDLE.
- `busy` = 1 in ISSUE, DRAIN and DONE.
- `err_overrun` is set on any of:
  - `step_req` while `busy` (the request is ignored);
  - `done_sig` in IDLE or DONE (the pulse is ignored);
  - `done_sig` that would push the count past `N_WT`.
- `err_overrun` and `err_timeout` clear only on `rst`.

## Timing
- Reset values: `busy`, `done_read`, `sta`, `step_done`, `err_overrun`, `err_timeout` = 0; `slot_idx` = 0; `first_step` = 1; FSM in IDLE; shift registers and counters cleared.
- `step_req` high in cycle t (IDLE):
  - `busy` goes high in t+1.
  - The k-th `done_read` (k = 0..N_WT−1) is in cycle t+1+k·SLOT_GAP.
  - The k-th `sta` is in cycle t+1+READ_LEAD+k·SLOT_GAP, with `slot_idx`=k.
- `step_done` is asserted one cycle after the cycle containing the `N_WT`-th `done_sig`. `busy` drops in the cycle after `step_done`.
- `step_req` in the same cycle as `step_done` is treated as busy: it is ignored and sets `err_overrun`.
- `rst` mid-sweep: all state returns to reset values on the next edge and any queued `sta` is discarded. `first_step` returns to 1.

## Configuration
- `PID_SCHED_WATCHDOG_EN` defined:
  - A watchdog counter runs in DRAIN, loaded when the last `sta` leaves the shift register.
  - If `PIPE_LAT`+4 cycles elapse without reaching `N_WT` completions, set `err_timeout`, pulse `step_done`, return to IDLE.
  - In this case `first_step` is NOT cleared.
- Not defined: no watchdog logic is compiled. `err_timeout` is tied 0 and DRAIN waits indefinitely.

## Test plan
Bench parameters: N_WT=4, READ_LEAD=15, SLOT_GAP=1, PIPE_LAT=20, macro defined unless noted.
- Nominal sweep: `step_req` at cycle 10, model returns `done_sig` 20 cycles after each `sta`.
  - Required: `done_read` at 11–14; `sta` at 26–29 with `slot_idx` 0,1,2,3; `done_sig` at 46–49; `step_done` at 50; `busy` low at 51; `first_step` low from 51; no error flags.
- SLOT_GAP=3, `step_req` at cycle 0.
  - Required: `done_read` at 1,4,7,10; `sta` at 16,19,22,25.
- `step_req` repeated at cycle 12 during nominal sweep.
  - Required: `err_overrun`=1 from 13; sweep timing unchanged; only 4 `sta`.
- Model drops the 4th `done_sig`, macro defined.
  - Required: `err_timeout`=1 and `step_done` 24 cycles after the last `sta` leaves the shift register; `first_step` stays 1.
  - Macro undefined: `busy` stays 1 indefinitely.
- `rst` at cycle 20 during nominal sweep.
  - Required: no `sta` at 26–29; all outputs at reset values from 21; a new `step_req` at 30 gives `sta` at 46–49.
- Spurious `done_sig` in IDLE.
  - Required: `err_overrun`=1; the next sweep still needs 4 completions for `step_done`.
